// File: rtl/sync_debounce_pkg.sv
// Shared helpers for the sync_debounce input conditioner: counter width
// derivation and the default debounce depth.
package sync_debounce_pkg;

  function automatic int clog2_min1(input int n);
    int w;
    w = 32'sd1;
    while ((64'd1 << w) < 64'(n)) begin
      w = w + 32'sd1;
    end
    return w;
  endfunction

  localparam int DEBOUNCE_CYCLES_DFLT = 32'sd16;
  localparam int DEBOUNCE_CW          = clog2_min1(DEBOUNCE_CYCLES_DFLT);

endpackage

// File: rtl/sync_debounce_ch.sv
// One conditioned channel: metastability chain, persistence counter,
// accepted level flop and registered rise/fall pulse flops.
module debounce_ch
  import sync_debounce_pkg::*;
#(
  parameter int   STAGES          = 32'sd2,
  parameter int   DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DFLT,
  parameter logic RST_VAL         = 1'b0
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_sig,
  output logic o_raw,
  output logic o_sig,
  output logic o_rise,
  output logic o_fall
);

  localparam int            CW       = clog2_min1(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 32'sd1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(32'sd1);
  localparam logic [CW-1:0] CNT_ZERO = CW'(32'sd0);

  logic [STAGES-1:0] sync_r;
  logic [CW-1:0]     cnt_r;
  logic [CW-1:0]     cnt_nxt_s;
  logic              raw_s;
  logic              sig_r;
  logic              sig_nxt_s;
  logic              rise_r;
  logic              rise_nxt_s;
  logic              fall_r;
  logic              fall_nxt_s;

  assign raw_s = sync_r[STAGES-1];

  // Synchroniser shift register; stages are back-to-back with no logic between
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_r <= {STAGES{RST_VAL}};
    end else begin
      sync_r <= {sync_r[STAGES-2:0], i_sig};
    end
  end

  // Acceptance decision: any agreeing cycle restarts the persistence count
  always_comb begin
    cnt_nxt_s  = cnt_r;
    sig_nxt_s  = sig_r;
    rise_nxt_s = 1'b0;
    fall_nxt_s = 1'b0;
    if (raw_s == sig_r) begin
      cnt_nxt_s = CNT_ZERO;
    end else if (cnt_r == CNT_LAST) begin
      cnt_nxt_s  = CNT_ZERO;
      sig_nxt_s  = raw_s;
      rise_nxt_s = raw_s;
      fall_nxt_s = ~raw_s;
    end else begin
      cnt_nxt_s = cnt_r + CNT_ONE;
    end
  end

  // Filter state and pulse registers; reset drops any pulse in flight
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_r  <= CNT_ZERO;
      sig_r  <= RST_VAL;
      rise_r <= 1'b0;
      fall_r <= 1'b0;
    end else begin
      cnt_r  <= cnt_nxt_s;
      sig_r  <= sig_nxt_s;
      rise_r <= rise_nxt_s;
      fall_r <= fall_nxt_s;
    end
  end

  assign o_raw  = raw_s;
  assign o_sig  = sig_r;
  assign o_rise = rise_r;
  assign o_fall = fall_r;

endmodule

// File: rtl/sync_debounce.sv
// Multi-channel pin-boundary conditioner: WIDTH independent copies of
// debounce_ch, each with its own reset level.
module sync_debounce
  import sync_debounce_pkg::*;
#(
  parameter int               WIDTH           = 32'sd4,
  parameter int               STAGES          = 32'sd2,
  parameter int               DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DFLT,
  parameter logic [WIDTH-1:0] RESET_VALUE     = {WIDTH{1'b0}}
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_sig,
  output logic [WIDTH-1:0] o_raw,
  output logic [WIDTH-1:0] o_sig,
  output logic [WIDTH-1:0] o_rise,
  output logic [WIDTH-1:0] o_fall
);

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    debounce_ch #(
      .STAGES          (STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RST_VAL         (RESET_VALUE[g])
    ) u_ch (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_sig   (i_sig[g]),
      .o_raw   (o_raw[g]),
      .o_sig   (o_sig[g]),
      .o_rise  (o_rise[g]),
      .o_fall  (o_fall[g])
    );
  end

endmodule

// File: tb/tb_sync_debounce.sv
// Scoreboard bench for sync_debounce: expected edge pulses are queued by the
// stimulus, a negedge monitor pops and compares every pulse the DUTs emit.
module tb_sync_debounce;

  logic       clk;
  logic       rst_n;
  logic [3:0] sig_a;
  logic [3:0] raw_a, osig_a, rise_a, fall_a;
  logic [0:0] sig_b;
  logic [0:0] raw_b, osig_b, rise_b, fall_b;

  int cyc   = 0;
  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int dut;
    int ch;
    bit rise;
    int cyc;
  } ev_t;

  ev_t sb_q[$];

  sync_debounce dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_sig(sig_a),
    .o_raw(raw_a), .o_sig(osig_a), .o_rise(rise_a), .o_fall(fall_a)
  );

  sync_debounce #(.WIDTH(1), .STAGES(3), .DEBOUNCE_CYCLES(1)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_sig(sig_b),
    .o_raw(raw_b), .o_sig(osig_b), .o_rise(rise_b), .o_fall(fall_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic push_ev(input int dut, input int ch, input bit rise, input int at);
    ev_t e;
    e.dut = dut; e.ch = ch; e.rise = rise; e.cyc = at;
    sb_q.push_back(e);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic got_ev(input int dut, input int ch, input bit rise);
    ev_t e;
    n_cmp++;
    if (sb_q.size() == 0) begin
      n_err++;
      $display("FAIL pulse: unexpected dut%0d ch%0d rise=%0d at cycle %0d", dut, ch, rise, cyc);
    end else begin
      e = sb_q.pop_front();
      if (e.dut != dut || e.ch != ch || e.rise != rise || e.cyc != cyc) begin
        n_err++;
        $display("FAIL pulse: got dut%0d ch%0d rise=%0d cyc=%0d, expected dut%0d ch%0d rise=%0d cyc=%0d",
                 dut, ch, rise, cyc, e.dut, e.ch, e.rise, e.cyc);
      end
    end
  endtask

  // Monitor: every pulse any DUT presents is matched against the queue head
  always @(negedge clk) begin
    for (int ch = 0; ch < 4; ch++) begin
      if (rise_a[ch]) got_ev(0, ch, 1'b1);
      if (fall_a[ch]) got_ev(0, ch, 1'b0);
    end
    if (rise_b[0]) got_ev(1, 0, 1'b1);
    if (fall_b[0]) got_ev(1, 0, 1'b0);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, %0d events pending", sb_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    rst_n = 1'b0;
    sig_a = 4'b1010;
    sig_b = 1'b0;
    wait_cyc(3);

    // reset state
    chk("rst_sig",  32'(osig_a), 32'h0);
    chk("rst_raw",  32'(raw_a),  32'h0);
    chk("rst_rise", 32'(rise_a), 32'h0);
    chk("rst_fall", 32'(fall_a), 32'h0);

    // release with inputs differing from reset value
    rst_n = 1'b1;
    c = cyc;
    push_ev(0, 1, 1'b1, c + 18);
    push_ev(0, 3, 1'b1, c + 18);
    wait_cyc(1);  chk("rel_raw_e1",  32'(raw_a),  32'h0);
    wait_cyc(1);  chk("rel_raw_e2",  32'(raw_a),  32'ha);
    wait_cyc(15); chk("rel_sig_e17", 32'(osig_a), 32'h0);
    wait_cyc(2);  chk("rel_sig_e19", 32'(osig_a), 32'ha);

    // return all channels low: falls on ch1 and ch3
    sig_a = 4'b0000;
    c = cyc;
    push_ev(0, 1, 1'b0, c + 18);
    push_ev(0, 3, 1'b0, c + 18);
    wait_cyc(20); chk("clr_sig", 32'(osig_a), 32'h0);

    // channel 0 step
    sig_a[0] = 1'b1;
    c = cyc;
    push_ev(0, 0, 1'b1, c + 18);
    wait_cyc(1);  chk("step_raw_e1",  32'(raw_a[0]),  32'h0);
    wait_cyc(1);  chk("step_raw_e2",  32'(raw_a[0]),  32'h1);
    wait_cyc(15); chk("step_sig_e17", 32'(osig_a[0]), 32'h0);
    wait_cyc(1);  chk("step_sig_e18", 32'(osig_a[0]), 32'h1);
    wait_cyc(1);  chk("step_rise_e19", 32'(rise_a[0]), 32'h0);

    // 15-clock glitch on channel 2
    sig_a[2] = 1'b1;
    wait_cyc(2);  chk("glitch_raw_e2",  32'(raw_a[2]), 32'h1);
    wait_cyc(13); sig_a[2] = 1'b0;
    wait_cyc(1);  chk("glitch_raw_e16", 32'(raw_a[2]), 32'h1);
    wait_cyc(1);  chk("glitch_raw_e17", 32'(raw_a[2]), 32'h0);
    wait_cyc(20); chk("glitch_sig", 32'(osig_a[2]), 32'h0);

    // bounce on channel 1, settling high
    for (int k = 0; k < 11; k++) begin
      if (k > 0) wait_cyc(3);
      sig_a[1] = ~sig_a[1];
    end
    c = cyc;
    push_ev(0, 1, 1'b1, c + 18);
    wait_cyc(17); chk("bounce_sig_e17", 32'(osig_a[1]), 32'h0);
    wait_cyc(1);  chk("bounce_sig_e18", 32'(osig_a[1]), 32'h1);
    wait_cyc(2);

    // reset mid-count on channel 3
    sig_a[3] = 1'b1;
    wait_cyc(10);
    rst_n = 1'b0;
    #1;
    chk("midrst_sig",  32'(osig_a), 32'h0);
    chk("midrst_rise", 32'(rise_a), 32'h0);
    wait_cyc(1);
    rst_n = 1'b1;
    c = cyc;
    push_ev(0, 0, 1'b1, c + 18);
    push_ev(0, 1, 1'b1, c + 18);
    push_ev(0, 3, 1'b1, c + 18);
    wait_cyc(17); chk("midrst_sig3_e17", 32'(osig_a[3]), 32'h0);
    wait_cyc(1);  chk("midrst_sig3_e18", 32'(osig_a[3]), 32'h1);
    wait_cyc(2);  chk("midrst_sig_all",  32'(osig_a), 32'hb);

    // unfiltered, 3-stage instance: single-cycle pulse
    sig_b = 1'b1;
    c = cyc;
    push_ev(1, 0, 1'b1, c + 4);
    push_ev(1, 0, 1'b0, c + 5);
    wait_cyc(1);  sig_b = 1'b0;
    wait_cyc(2);  chk("b_sig_e3", 32'(osig_b), 32'h0);
    wait_cyc(1);  chk("b_sig_e4", 32'(osig_b), 32'h1);
    wait_cyc(1);  chk("b_sig_e5", 32'(osig_b), 32'h0);

    wait_cyc(5);
    chk("sb_drained", 32'(sb_q.size()), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
